tmr_vote_monitor: RTL and testbench

Downstream consumer of a triplicated block: receives the three replica outputs of a `tamara_triplicate` instance (e.g. the three 2-bit counter copies) and produces a registered bitwise-majority result. It detects and counts replica disagreement and attributes persistent faults to a single replica. It drives a req/ack resync handshake so the replicas can be reloaded. It sits between the triplicated instance and the logic that previously used its single output.

---
 rtl/tmr_vote_monitor.sv | 139 +++++++++++++
 tb/tb_tmr_vote_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_vote_monitor.sv
// Bitwise TMR voter with mismatch counting, per-replica fault attribution and resync req/ack.
// 1-cycle latency on vote/flags; no backpressure, a sample is consumed every cycle i_valid is high.
module tmr_vote_monitor #(
  parameter int WIDTH   = 2,
  parameter int PERSIST = 4,
  parameter int CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_rep_a,
  input  logic [WIDTH-1:0] i_rep_b,
  input  logic [WIDTH-1:0] i_rep_c,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_voted,
  output logic             o_mismatch,
  output logic             o_multi_fault,
  output logic [CNT_W-1:0] o_fault_cnt,
  output logic [2:0]       o_failed,
  output logic             o_resync_req,
  input  logic             i_resync_ack
);

  localparam logic [1:0] MONITOR  = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;
  localparam logic [7:0] PERSIST_8 = PERSIST[7:0];

  logic [1:0]       state_q, state_d;
  logic             cd_q, cd_d;
  logic [2:0][7:0]  pc_q, pc_d;
  logic [2:0]       failed_q, failed_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic             valid_q, mismatch_q, multi_q;
  logic [WIDTH-1:0] voted_q;

  logic [WIDTH-1:0] voted_c;
  logic [2:0]       dis;
  logic [2:0]       hit;
  logic [2:0][7:0]  pc_inc;
  logic             mismatch_c, multi_c;

  always_comb begin
    voted_c    = (i_rep_a & i_rep_b) | (i_rep_a & i_rep_c) | (i_rep_b & i_rep_c);
    dis[0]     = |(i_rep_a ^ voted_c);
    dis[1]     = |(i_rep_b ^ voted_c);
    dis[2]     = |(i_rep_c ^ voted_c);
    mismatch_c = |dis;
    multi_c    = (dis[0] & dis[1]) | (dis[0] & dis[2]) | (dis[1] & dis[2]);
    for (int k = 0; k < 3; k++) begin
      pc_inc[k] = pc_q[k] + 8'd1;
      hit[k]    = dis[k] && (pc_inc[k] == PERSIST_8);
    end
  end

  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    pc_d     = pc_q;
    failed_d = failed_q;
    case (state_q)
      MONITOR: begin
        if (i_valid) begin
          if (|hit) begin
            // Every replica crossing the threshold on this edge is blamed; one request covers all.
            state_d  = REQ;
            failed_d = failed_q | hit;
            pc_d     = '0;
          end else begin
            for (int k = 0; k < 3; k++) begin
              pc_d[k] = dis[k] ? pc_inc[k] : 8'd0;
            end
          end
        end
      end
      REQ: begin
        if (i_resync_ack) begin
          state_d  = COOLDOWN;
          failed_d = '0;
          cd_d     = 1'b0;
        end
      end
      COOLDOWN: begin
        pc_d = '0;
        cd_d = ~cd_q;
        if (cd_q) begin
          state_d = MONITOR;
        end
      end
      default: begin
        state_d = MONITOR;
        pc_d    = '0;
        cd_d    = 1'b0;
      end
    endcase
  end

  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (i_valid && mismatch_c && (fault_cnt_q != {CNT_W{1'b1}})) begin
      fault_cnt_d = fault_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= MONITOR;
      cd_q        <= 1'b0;
      pc_q        <= '0;
      failed_q    <= '0;
      fault_cnt_q <= '0;
      valid_q     <= 1'b0;
      voted_q     <= '0;
      mismatch_q  <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cd_q        <= cd_d;
      pc_q        <= pc_d;
      failed_q    <= failed_d;
      fault_cnt_q <= fault_cnt_d;
      valid_q     <= i_valid;
      mismatch_q  <= i_valid & mismatch_c;
      multi_q     <= i_valid & multi_c;
      if (i_valid) begin
        voted_q <= voted_c;
      end
    end
  end

  assign o_valid       = valid_q;
  assign o_voted       = voted_q;
  assign o_mismatch    = mismatch_q;
  assign o_multi_fault = multi_q;
  assign o_fault_cnt   = fault_cnt_q;
  assign o_failed      = failed_q;
  assign o_resync_req  = (state_q == REQ);

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares after every edge.
module tb_tmr_vote_monitor;

  localparam int PERSIST = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             v;
    logic [1:0]       voted;
    logic             mis;
    logic             multi;
    logic [CNT_W-1:0] fcnt;
    logic [2:0]       failed;
    logic             req;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid;
  logic [1:0]       rep_a, rep_b, rep_c;
  logic             ack;
  logic             o_valid, o_mismatch, o_multi_fault, o_resync_req;
  logic [1:0]       o_voted;
  logic [CNT_W-1:0] o_fault_cnt;
  logic [2:0]       o_failed;

  tmr_vote_monitor #(.WIDTH(2), .PERSIST(PERSIST), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
    .i_rep_a(rep_a), .i_rep_b(rep_b), .i_rep_c(rep_c),
    .o_valid(o_valid), .o_voted(o_voted), .o_mismatch(o_mismatch),
    .o_multi_fault(o_multi_fault), .o_fault_cnt(o_fault_cnt), .o_failed(o_failed),
    .o_resync_req(o_resync_req), .i_resync_ack(ack)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: mode 0 = watching, 1 = requesting, 2 = cooling down.
  int         m_mode = 0;
  int         m_cool_left = 0;
  int         m_streak[3] = '{0, 0, 0};
  logic [2:0] m_failed = '0;
  int         m_fcnt = 0;
  logic [1:0] m_voted = '0;

  task automatic model(input logic v, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] c, input logic ak, input logic rn);
    exp_t       e;
    logic [1:0] vote;
    logic [1:0] r[3];
    int         nd;
    bit         any_new;
    e = '0;
    if (!rn) begin
      m_mode = 0; m_cool_left = 0; m_failed = '0; m_fcnt = 0; m_voted = '0;
      for (int k = 0; k < 3; k++) m_streak[k] = 0;
    end else begin
      r[0] = a; r[1] = b; r[2] = c;
      for (int j = 0; j < 2; j++) begin
        vote[j] = ((int'(a[j]) + int'(b[j]) + int'(c[j])) >= 2);
      end
      nd = 0;
      for (int k = 0; k < 3; k++) if (r[k] != vote) nd++;
      if (v) begin
        m_voted = vote;
        e.mis   = (nd > 0);
        e.multi = (nd >= 2);
        if (nd > 0 && m_fcnt < CNT_MAX) m_fcnt++;
      end
      if (m_mode == 0) begin
        if (v) begin
          any_new = 0;
          for (int k = 0; k < 3; k++) begin
            m_streak[k] = (r[k] != vote) ? m_streak[k] + 1 : 0;
            if (m_streak[k] >= PERSIST) begin
              m_failed[k] = 1'b1;
              any_new = 1;
            end
          end
          if (any_new) begin
            m_mode = 1;
            for (int k = 0; k < 3; k++) m_streak[k] = 0;
          end
        end
      end else if (m_mode == 1) begin
        if (ak) begin
          m_mode = 2; m_cool_left = 2; m_failed = '0;
        end
      end else begin
        m_cool_left--;
        if (m_cool_left == 0) m_mode = 0;
      end
      e.v = v;
    end
    e.voted  = m_voted;
    e.fcnt   = m_fcnt[CNT_W-1:0];
    e.failed = m_failed;
    e.req    = (m_mode == 1);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic v, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input logic ak, input logic rn);
    valid = v; rep_a = a; rep_b = b; rep_c = c; ack = ak; rst_n = rn;
    model(v, a, b, c, ak, rn);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  // Monitor: the DUT presents a full output set after every edge.
  initial begin
    exp_t e, act;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act.v = o_valid; act.voted = o_voted; act.mis = o_mismatch;
        act.multi = o_multi_fault; act.fcnt = o_fault_cnt;
        act.failed = o_failed; act.req = o_resync_req;
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL vec%0d t=%0t got v=%b vote=%b mis=%b multi=%b cnt=%0d failed=%b req=%b exp v=%b vote=%b mis=%b multi=%b cnt=%0d failed=%b req=%b",
                   vectors, $time, act.v, act.voted, act.mis, act.multi, act.fcnt, act.failed, act.req,
                   e.v, e.voted, e.mis, e.multi, e.fcnt, e.failed, e.req);
        end
      end
    end
  end

  initial begin
    logic [1:0] base, wv;
    int         bad, bad2;
    logic [1:0] r[3];
    logic       v, ak, rn;
    rst_n = 1'b0; valid = 1'b0; rep_a = '0; rep_b = '0; rep_c = '0; ack = 1'b0;
    #3;
    do_reset(); do_reset();

    // Agreement
    repeat (10) step(1'b1, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1);
    step(1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1);
    step(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1);

    // Single transient on b
    repeat (3) step(1'b1, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1);
    repeat (3) step(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    do_reset();

    // Persistent c fault, stalled ack, pulse, cooldown, re-declare
    repeat (4) step(1'b1, 2'b01, 2'b01, 2'b10, 1'b0, 1'b1);
    repeat (5) step(1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1);
    step(1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 1'b1);
    repeat (2) step(1'b1, 2'b01, 2'b01, 2'b10, 1'b0, 1'b1);
    repeat (4) step(1'b1, 2'b01, 2'b01, 2'b10, 1'b0, 1'b1);
    step(1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 1'b1);
    repeat (3) step(1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1);
    do_reset();

    // Gap keeps the persistence count, then a multi-fault sample
    repeat (3) step(1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
    repeat (2) step(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
    step(1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
    step(1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    step(1'b1, 2'b01, 2'b10, 2'b00, 1'b0, 1'b1);
    repeat (2) step(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    do_reset();

    // Saturation of the mismatch counter
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'b10, 2'b00, 2'b00, (i % 3) == 0, 1'b1);
    end
    do_reset();

    // Reset while requesting, then a late ack
    repeat (4) step(1'b1, 2'b01, 2'b01, 2'b10, 1'b0, 1'b1);
    step(1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1);
    step(1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0);
    repeat (2) step(1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 1'b1);
    step(1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1);

    // Randomized traffic with sticky faulty replicas
    bad = 3; bad2 = 3;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) bad = $urandom_range(0, 3);
      bad2 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : 3;
      base = 2'($urandom_range(0, 3));
      for (int k = 0; k < 3; k++) r[k] = base;
      if (bad < 3) begin
        wv = 2'($urandom_range(1, 3));
        r[bad] = base ^ wv;
      end
      if (bad2 < 3) begin
        wv = 2'($urandom_range(1, 3));
        r[bad2] = base ^ wv;
      end
      v  = ($urandom_range(0, 9) < 8);
      ak = ($urandom_range(0, 3) == 0);
      rn = ($urandom_range(0, 299) != 0);
      step(v, r[0], r[1], r[2], ak, rn);
    end

    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
